// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath: activation format, skew-feeder FSM
// states and a small sizing helper.
package tpu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // Signed Q8.8 activation, identical to the format the PEs consume.
    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] fxp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } skew_state_e;

    // Counter width that still yields one bit when only a single value is needed.
    function automatic int cnt_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register carrying a data word plus a valid bit; shifts only
// when enabled so the whole wavefront freezes together.
module delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            valid_q;

    // NOTE: every stage is reset (not just the valid bits) because a reset in
    // mid-stream must present zero data to the array immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments let each stage sample the old
            // value of its neighbour, which is what makes this a shift.
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skew.sv
// Systolic-array input feeder: accepts one activation vector per cycle and skews
// lane r by r cycles, then flushes zero bubbles and pulses done.
module systolic_input_skew
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ROWS       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                       in_last,
    output logic [ROWS*DATA_WIDTH-1:0] out_data,
    output logic [ROWS-1:0]            out_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int             CNT_W    = cnt_width(ROWS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ROWS > 1) ? ROWS - 2 : 0);

    skew_state_e state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             done_next;
    logic             accept;
    logic [ROWS*DATA_WIDTH-1:0] lane_in;

    assign in_ready = rst && advance && (state != DRAIN);
    assign accept   = in_valid && in_ready;
    // Bubbles must be zero so they contribute nothing to the PE accumulators.
    assign lane_in  = accept ? in_data : '0;

    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        if (advance) begin
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (!in_last) begin
                            state_next = STREAM;
                        end else if (ROWS > 1) begin
                            state_next = DRAIN;
                            cnt_next   = '0;
                        end else begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The final advance of the drain pushes the last lane out.
                    if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
            busy  <= (state_next != IDLE);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        delay_line #(
            .DEPTH (r + 1),
            .WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_data   (lane_in[r*DATA_WIDTH +: DATA_WIDTH]),
            .in_valid  (accept),
            .out_data  (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (out_valid[r])
        );
    end

endmodule
